// File: rtl/hp0_wr_sched.sv
// hp0_wr_sched: round-robin write-burst scheduler for two on-chip requesters
// (req0 = GE capture path, req1 = sample path) onto the PS S_AXI_HP0 AXI3
// slave port. Only one burst is in flight at a time. Each burst goes through
// AW, W and B, and its outcome is reported back as a done/err pulse.
module hp0_wr_sched #(
   parameter int unsigned ID_W    = 6,
   parameter logic [3:0]  AWCACHE = 4'b0011,
   parameter logic [3:0]  AWQOS   = 4'h0
) (
   input  logic            clk,
   input  logic            rst_n,
   // requester 0
   input  logic            req0_valid,
   input  logic [31:0]     req0_addr,
   input  logic [3:0]      req0_len,
   output logic            req0_ready,
   input  logic [31:0]     req0_data,
   output logic            req0_rd,
   output logic            req0_done,
   output logic            req0_err,
   // requester 1
   input  logic            req1_valid,
   input  logic [31:0]     req1_addr,
   input  logic [3:0]      req1_len,
   output logic            req1_ready,
   input  logic [31:0]     req1_data,
   output logic            req1_rd,
   output logic            req1_done,
   output logic            req1_err,
   // AXI3 write address channel
   output logic [31:0]     axi_awaddr,
   output logic [3:0]      axi_awlen,
   output logic [2:0]      axi_awsize,
   output logic [1:0]      axi_awburst,
   output logic [1:0]      axi_awlock,
   output logic [3:0]      axi_awcache,
   output logic [2:0]      axi_awprot,
   output logic [3:0]      axi_awqos,
   output logic [ID_W-1:0] axi_awid,
   output logic            axi_awvalid,
   input  logic            axi_awready,
   // AXI3 write data channel
   output logic [31:0]     axi_wdata,
   output logic [3:0]      axi_wstrb,
   output logic            axi_wlast,
   output logic [ID_W-1:0] axi_wid,
   output logic            axi_wvalid,
   input  logic            axi_wready,
   // AXI3 write response channel
   input  logic [ID_W-1:0] axi_bid,
   input  logic [1:0]      axi_bresp,
   input  logic            axi_bvalid,
   output logic            axi_bready,
   // status
   output logic            busy
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_REJECT = 3'd1,
      ST_AW     = 3'd2,
      ST_W      = 3'd3,
      ST_B      = 3'd4
   } state_t;

   // A burst is refused if it is not word aligned, or if it would run past
   // the end of its 4 KB page. A burst that ends exactly at the 4096 boundary
   // is legal.
   function automatic logic bad_request(input logic [31:0] addr, input logic [3:0] len);
      logic [4:0]  beats;
      logic [12:0] end_off;
      beats   = {1'b0, len} + 5'd1;
      end_off = {1'b0, addr[11:0]} + {6'b000000, beats, 2'b00};
      bad_request = (addr[1:0] != 2'b00) || (end_off > 13'd4096);
   endfunction

   // The AXI ID only carries the granted requester in bit 0.
   function automatic logic [ID_W-1:0] make_id(input logic g);
      make_id    = {ID_W{1'b0}};
      make_id[0] = g;
   endfunction

   state_t      state_q,      state_d;
   logic        last_grant_q, last_grant_d;
   logic        grant_q,      grant_d;
   logic [31:0] addr_q,       addr_d;
   logic [3:0]  len_q,        len_d;
   logic [3:0]  beat_q,       beat_d;
   logic        awvalid_q,    awvalid_d;
   logic        wvalid_q,     wvalid_d;
   logic        bready_q,     bready_d;
   logic        busy_q,       busy_d;
   logic [1:0]  ready_q,      ready_d;
   logic [1:0]  done_q,       done_d;
   logic [1:0]  err_q,        err_d;

   logic        pick_s;
   logic [31:0] pick_addr_s;
   logic [3:0]  pick_len_s;
   logic        beat_acc_s;
   logic        last_beat_s;
   logic        b_err_s;

   // Arbitration: a single requester wins outright. On a tie, the requester
   // that did not win last time wins.
   always_comb begin
      pick_s      = 1'b0;
      pick_addr_s = req0_addr;
      pick_len_s  = req0_len;
      if (req0_valid && req1_valid) begin
         pick_s = ~last_grant_q;
      end else if (req1_valid) begin
         pick_s = 1'b1;
      end else begin
         pick_s = 1'b0;
      end
      if (pick_s) begin
         pick_addr_s = req1_addr;
         pick_len_s  = req1_len;
      end else begin
         pick_addr_s = req0_addr;
         pick_len_s  = req0_len;
      end
   end

   // W-beat handshake and B-response status decode.
   always_comb begin
      beat_acc_s  = wvalid_q & axi_wready;
      last_beat_s = (beat_q == len_q);
      b_err_s     = (axi_bresp != 2'b00) || (axi_bid != make_id(grant_q));
   end

   // Next-state and next-output computation for the scheduler FSM.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      grant_d      = grant_q;
      addr_d       = addr_q;
      len_d        = len_q;
      beat_d       = beat_q;
      awvalid_d    = awvalid_q;
      wvalid_d     = wvalid_q;
      bready_d     = bready_q;
      ready_d      = 2'b00;
      done_d       = 2'b00;
      err_d        = 2'b00;
      case (state_q)
         ST_IDLE: begin
            if (req0_valid || req1_valid) begin
               grant_d      = pick_s;
               last_grant_d = pick_s;
               ready_d      = pick_s ? 2'b10 : 2'b01;
               if (bad_request(pick_addr_s, pick_len_s)) begin
                  done_d  = pick_s ? 2'b10 : 2'b01;
                  err_d   = pick_s ? 2'b10 : 2'b01;
                  state_d = ST_REJECT;
               end else begin
                  addr_d    = pick_addr_s;
                  len_d     = pick_len_s;
                  beat_d    = 4'd0;
                  awvalid_d = 1'b1;
                  state_d   = ST_AW;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_REJECT: begin
            state_d = ST_IDLE;
         end
         ST_AW: begin
            if (axi_awready) begin
               awvalid_d = 1'b0;
               wvalid_d  = 1'b1;
               state_d   = ST_W;
            end else begin
               state_d = ST_AW;
            end
         end
         ST_W: begin
            if (beat_acc_s) begin
               if (last_beat_s) begin
                  wvalid_d = 1'b0;
                  bready_d = 1'b1;
                  state_d  = ST_B;
               end else begin
                  beat_d = beat_q + 4'd1;
               end
            end else begin
               state_d = ST_W;
            end
         end
         ST_B: begin
            if (axi_bvalid) begin
               bready_d = 1'b0;
               done_d   = grant_q ? 2'b10 : 2'b01;
               if (b_err_s) begin
                  err_d = grant_q ? 2'b10 : 2'b01;
               end else begin
                  err_d = 2'b00;
               end
               state_d = ST_IDLE;
            end else begin
               state_d = ST_B;
            end
         end
         default: begin
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
            bready_d  = 1'b0;
            state_d   = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and registered-output flops. Reset abandons any burst in flight,
   // because the PS side is reset together with this block.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         last_grant_q <= 1'b1;
         grant_q      <= 1'b0;
         addr_q       <= 32'h0000_0000;
         len_q        <= 4'd0;
         beat_q       <= 4'd0;
         awvalid_q    <= 1'b0;
         wvalid_q     <= 1'b0;
         bready_q     <= 1'b0;
         busy_q       <= 1'b0;
         ready_q      <= 2'b00;
         done_q       <= 2'b00;
         err_q        <= 2'b00;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_q      <= grant_d;
         addr_q       <= addr_d;
         len_q        <= len_d;
         beat_q       <= beat_d;
         awvalid_q    <= awvalid_d;
         wvalid_q     <= wvalid_d;
         bready_q     <= bready_d;
         busy_q       <= busy_d;
         ready_q      <= ready_d;
         done_q       <= done_d;
         err_q        <= err_d;
      end
   end

   // W data comes straight from the winner's FWFT FIFO head. It is zero
   // outside the data phase, and the pop strobe follows the beat handshake.
   always_comb begin
      if (wvalid_q) begin
         if (grant_q) begin
            axi_wdata = req1_data;
         end else begin
            axi_wdata = req0_data;
         end
      end else begin
         axi_wdata = 32'h0000_0000;
      end
      axi_wlast = wvalid_q & last_beat_s;
      req0_rd   = beat_acc_s & ~grant_q;
      req1_rd   = beat_acc_s &  grant_q;
   end

   assign axi_awaddr  = addr_q;
   assign axi_awlen   = len_q;
   assign axi_awsize  = 3'b010;
   assign axi_awburst = 2'b01;
   assign axi_awlock  = 2'b00;
   assign axi_awcache = AWCACHE;
   assign axi_awprot  = 3'b000;
   assign axi_awqos   = AWQOS;
   assign axi_awid    = make_id(grant_q);
   assign axi_awvalid = awvalid_q;
   assign axi_wstrb   = 4'hF;
   assign axi_wid     = make_id(grant_q);
   assign axi_wvalid  = wvalid_q;
   assign axi_bready  = bready_q;
   assign busy        = busy_q;
   assign req0_ready  = ready_q[0];
   assign req1_ready  = ready_q[1];
   assign req0_done   = done_q[0];
   assign req1_done   = done_q[1];
   assign req0_err    = err_q[0];
   assign req1_err    = err_q[1];

endmodule

// File: tb/tb_hp0_wr_sched.sv
// Directed testbench for hp0_wr_sched. Inputs are driven on the falling
// edge, and outputs are sampled 1 ns later. Each requester FIFO is modelled
// as a counter-based data source that pops on reqN_rd.
`timescale 1ns/1ps
module tb_hp0_wr_sched;
   localparam int ID_W = 6;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            req0_valid, req0_ready, req0_rd, req0_done, req0_err;
   logic [31:0]     req0_addr, req0_data;
   logic [3:0]      req0_len;
   logic            req1_valid, req1_ready, req1_rd, req1_done, req1_err;
   logic [31:0]     req1_addr, req1_data;
   logic [3:0]      req1_len;
   logic [31:0]     axi_awaddr, axi_wdata;
   logic [3:0]      axi_awlen, axi_awcache, axi_awqos, axi_wstrb;
   logic [2:0]      axi_awsize, axi_awprot;
   logic [1:0]      axi_awburst, axi_awlock, axi_bresp;
   logic [ID_W-1:0] axi_awid, axi_wid, axi_bid;
   logic            axi_awvalid, axi_awready, axi_wlast, axi_wvalid, axi_wready;
   logic            axi_bvalid, axi_bready, busy;

   int pop0 = 0;
   int pop1 = 0;
   int exp_cnt [2];
   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   assign req0_data = 32'hA000_0000 + 32'(pop0);
   assign req1_data = 32'hB000_0000 + 32'(pop1);

   always @(posedge clk) begin
      if (req0_rd) pop0 <= pop0 + 1;
      if (req1_rd) pop1 <= pop1 + 1;
   end

   hp0_wr_sched #(.ID_W(ID_W), .AWCACHE(4'b0011), .AWQOS(4'h0)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_len(req0_len), .req0_ready(req0_ready),
      .req0_data(req0_data), .req0_rd(req0_rd), .req0_done(req0_done), .req0_err(req0_err),
      .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_len(req1_len), .req1_ready(req1_ready),
      .req1_data(req1_data), .req1_rd(req1_rd), .req1_done(req1_done), .req1_err(req1_err),
      .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize), .axi_awburst(axi_awburst),
      .axi_awlock(axi_awlock), .axi_awcache(axi_awcache), .axi_awprot(axi_awprot), .axi_awqos(axi_awqos),
      .axi_awid(axi_awid), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
      .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast), .axi_wid(axi_wid),
      .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
      .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
      .busy(busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic sel(input int n, input logic a, input logic b);
      return (n == 0) ? a : b;
   endfunction

   task automatic set_req(input int n, input logic v, input logic [31:0] a, input logic [3:0] l);
      if (n == 0) begin
         req0_valid = v; req0_addr = a; req0_len = l;
      end else begin
         req1_valid = v; req1_addr = a; req1_len = l;
      end
   endtask

   // Runs one complete burst for requester n and checks AW, every W beat and B.
   task automatic run_burst(input int n, input bit new_req, input logic [31:0] a, input logic [3:0] l,
                            input bit w_rand, input int aw_stall, input logic [1:0] bresp,
                            input bit bid_bad, input logic exp_err);
      int guard;
      int beats;
      int pop_start;
      bit seen;
      logic [31:0] dbase;
      dbase     = (n == 0) ? 32'hA000_0000 : 32'hB000_0000;
      pop_start = (n == 0) ? pop0 : pop1;
      if (new_req) begin
         @(negedge clk);
         axi_awready = (aw_stall == 0);
         set_req(n, 1'b1, a, l);
      end else begin
         axi_awready = (aw_stall == 0);
      end
      seen  = 1'b0;
      guard = 0;
      while (!seen && guard < 20) begin
         @(negedge clk); #1;
         guard++;
         if (axi_awvalid) seen = 1'b1;
      end
      check("aw_seen", 32'(seen), 32'd1);
      check("ready", 32'(sel(n, req0_ready, req1_ready)), 32'd1);
      check("ready_other", 32'(sel(n, req1_ready, req0_ready)), 32'd0);
      check("awaddr", axi_awaddr, a);
      check("awlen", 32'(axi_awlen), 32'(l));
      check("awid", 32'(axi_awid), 32'(n));
      set_req(n, 1'b0, a, l);
      for (int k = 0; k < aw_stall; k++) begin
         @(negedge clk); #1;
         check("aw_hold_valid", 32'(axi_awvalid), 32'd1);
         check("aw_hold_addr", axi_awaddr, a);
      end
      axi_awready = 1'b1;
      beats = 0;
      guard = 0;
      while (beats <= int'(l) && guard < 300) begin
         @(negedge clk);
         axi_wready = w_rand ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         guard++;
         if (axi_wvalid) begin
            check("wdata", axi_wdata, dbase + 32'(exp_cnt[n]));
            check("wlast", 32'(axi_wlast), 32'(beats == int'(l)));
            check("wid", 32'(axi_wid), 32'(n));
            if (axi_wready) begin
               check("rd", 32'(sel(n, req0_rd, req1_rd)), 32'd1);
               exp_cnt[n]++;
               beats++;
            end else begin
               check("rd_stall", 32'(sel(n, req0_rd, req1_rd)), 32'd0);
            end
         end
      end
      check("beats", 32'(beats), 32'(int'(l) + 1));
      @(negedge clk);
      axi_wready = 1'b0;
      axi_bvalid = 1'b1;
      axi_bresp  = bresp;
      axi_bid    = bid_bad ? ID_W'(n ^ 1) : ID_W'(n);
      #1;
      check("bready", 32'(axi_bready), 32'd1);
      check("wvalid_off", 32'(axi_wvalid), 32'd0);
      @(negedge clk);
      axi_bvalid = 1'b0;
      axi_bresp  = 2'b00;
      axi_bid    = '0;
      #1;
      check("done", 32'(sel(n, req0_done, req1_done)), 32'd1);
      check("err", 32'(sel(n, req0_err, req1_err)), 32'(exp_err));
      check("done_other", 32'(sel(n, req1_done, req0_done)), 32'd0);
      check("busy_idle", 32'(busy), 32'd0);
      check("rd_pulses", 32'(((n == 0) ? pop0 : pop1) - pop_start), 32'(int'(l) + 1));
   endtask

   // A request that must be refused: ready/done/err pulse together with no AXI activity.
   task automatic run_reject(input int n, input logic [31:0] a, input logic [3:0] l);
      @(negedge clk);
      set_req(n, 1'b1, a, l);
      @(negedge clk); #1;
      check("rej_ready", 32'(sel(n, req0_ready, req1_ready)), 32'd1);
      check("rej_done", 32'(sel(n, req0_done, req1_done)), 32'd1);
      check("rej_err", 32'(sel(n, req0_err, req1_err)), 32'd1);
      check("rej_awvalid", 32'(axi_awvalid), 32'd0);
      check("rej_busy", 32'(busy), 32'd1);
      set_req(n, 1'b0, a, l);
      @(negedge clk); #1;
      check("rej_idle", 32'(busy), 32'd0);
      check("rej_done_clear", 32'(sel(n, req0_done, req1_done)), 32'd0);
      check("rej_no_aw", 32'(axi_awvalid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_cnt[0] = 0;
      exp_cnt[1] = 0;
      rst_n = 1'b0;
      set_req(0, 1'b0, 32'h0, 4'd0);
      set_req(1, 1'b0, 32'h0, 4'd0);
      axi_awready = 1'b1; axi_wready = 1'b0;
      axi_bvalid = 1'b0; axi_bresp = 2'b00; axi_bid = '0;
      #2;
      // reset state
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_awvalid", 32'(axi_awvalid), 32'd0);
      check("rst_wvalid", 32'(axi_wvalid), 32'd0);
      check("rst_bready", 32'(axi_bready), 32'd0);
      check("rst_awaddr", axi_awaddr, 32'h0);
      check("rst_awlen", 32'(axi_awlen), 32'd0);
      check("rst_wdata", axi_wdata, 32'h0);
      check("rst_ready", 32'({req0_ready, req1_ready, req0_done, req1_done}), 32'd0);
      check("rst_awsize", 32'(axi_awsize), 32'd2);
      check("rst_awburst", 32'(axi_awburst), 32'd1);
      check("rst_awlock_prot", 32'({axi_awlock, axi_awprot}), 32'd0);
      check("rst_awcache", 32'(axi_awcache), 32'd3);
      check("rst_awqos", 32'(axi_awqos), 32'd0);
      check("rst_wstrb", 32'(axi_wstrb), 32'hF);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // tie straight out of reset: req0 first, then req1
      @(negedge clk);
      set_req(0, 1'b1, 32'h1000_0000, 4'd3);
      set_req(1, 1'b1, 32'h1000_0100, 4'd1);
      run_burst(0, 1'b0, 32'h1000_0000, 4'd3, 1'b0, 0, 2'b00, 1'b0, 1'b0);
      run_burst(1, 1'b0, 32'h1000_0100, 4'd1, 1'b0, 0, 2'b00, 1'b0, 1'b0);

      // req0 alone, full 16-beat burst
      run_burst(0, 1'b1, 32'h1000_0000, 4'd15, 1'b0, 0, 2'b00, 1'b0, 1'b0);

      // tie after req0 was last served: req1 wins, then req0
      @(negedge clk);
      set_req(0, 1'b1, 32'h1000_0040, 4'd2);
      set_req(1, 1'b1, 32'h1000_0140, 4'd2);
      run_burst(1, 1'b0, 32'h1000_0140, 4'd2, 1'b0, 0, 2'b00, 1'b0, 1'b0);
      run_burst(0, 1'b0, 32'h1000_0040, 4'd2, 1'b0, 0, 2'b00, 1'b0, 1'b0);

      // 4 KB crossing is rejected; ending exactly at 4096 is legal
      run_reject(1, 32'h1000_0FF0, 4'd4);
      run_burst(0, 1'b1, 32'h1000_0FC0, 4'd15, 1'b0, 0, 2'b00, 1'b0, 1'b0);
      // misaligned address is rejected
      run_reject(0, 32'h1000_0002, 4'd0);

      // random W stalls on an 8-beat burst, plus 2 AW stall cycles
      run_burst(1, 1'b1, 32'h1000_0200, 4'd7, 1'b1, 2, 2'b00, 1'b0, 1'b0);

      // SLVERR on req1, then a normal single-beat req0 burst
      run_burst(1, 1'b1, 32'h1000_0300, 4'd2, 1'b0, 0, 2'b10, 1'b0, 1'b1);
      run_burst(0, 1'b1, 32'h1000_0400, 4'd0, 1'b0, 0, 2'b00, 1'b0, 1'b0);
      // BID mismatch flags an error
      run_burst(0, 1'b1, 32'h1000_0500, 4'd1, 1'b0, 0, 2'b00, 1'b1, 1'b1);

      // reset asserted during the third W beat
      @(negedge clk);
      axi_awready = 1'b1;
      axi_wready  = 1'b1;
      set_req(0, 1'b1, 32'h1000_0600, 4'd7);
      @(negedge clk); #1;
      check("mr_awvalid", 32'(axi_awvalid), 32'd1);
      set_req(0, 1'b0, 32'h1000_0600, 4'd7);
      @(negedge clk); #1;
      check("mr_beat0", axi_wdata, 32'hA000_0000 + 32'(exp_cnt[0]));
      @(negedge clk); #1;
      @(negedge clk); #1;
      check("mr_beat2", axi_wdata, 32'hA000_0000 + 32'(exp_cnt[0] + 2));
      check("mr_wvalid_pre", 32'(axi_wvalid), 32'd1);
      rst_n = 1'b0;
      #1;
      check("mr_wvalid", 32'(axi_wvalid), 32'd0);
      check("mr_awvalid_rst", 32'(axi_awvalid), 32'd0);
      check("mr_bready", 32'(axi_bready), 32'd0);
      check("mr_busy", 32'(busy), 32'd0);
      check("mr_rd", 32'(req0_rd), 32'd0);
      check("mr_wlast", 32'(axi_wlast), 32'd0);
      check("mr_awaddr", axi_awaddr, 32'h0);
      exp_cnt[0] = exp_cnt[0] + 2;
      axi_wready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      // operation resumes normally after reset
      run_burst(1, 1'b1, 32'h1000_0700, 4'd1, 1'b0, 0, 2'b00, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
